// File: rtl/io_sram_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : io_sram_responder_if
// Purpose  : M32632 general-purpose IO bus bundle between the CPU-side
//            requester (master) and the SRAM responder (slave).
// Signals  : sel      - external address decode hit
//            io_rd    - read request, held until io_ready
//            io_wr    - write request, held until io_ready
//            io_a     - byte address [ADDR_W:0], bits [1:0] unused
//            io_be    - byte enables, [1:0] low half, [3:2] high half
//            io_di    - write data
//            io_q     - read data, valid while io_ready=1
//            io_ready - single-cycle access-complete pulse
// Revision : 1.0 - initial release
// ============================================================================
interface io_sram_responder_if #(
  parameter int ADDR_W = 20
);
  logic              sel;
  logic              io_rd;
  logic              io_wr;
  logic [ADDR_W:0]   io_a;
  logic [3:0]        io_be;
  logic [31:0]       io_di;
  logic [31:0]       io_q;
  logic              io_ready;

  modport master (
    output sel, io_rd, io_wr, io_a, io_be, io_di,
    input  io_q, io_ready
  );

  modport slave (
    input  sel, io_rd, io_wr, io_a, io_be, io_di,
    output io_q, io_ready
  );
endinterface

`default_nettype wire

// File: rtl/io_sram_responder.sv
`default_nettype none
// ============================================================================
// Module   : io_sram_responder
// Purpose  : Turns each 32-bit M32632 IO bus access into one or two 16-bit
//            asynchronous SRAM cycles (SETUP / STROBE / HOLD per half) with
//            byte-lane-correct writes and programmable strobe wait states,
//            then issues a registered one-cycle io_ready.
// Ports    : clk        - system clock (CPU BCLK domain)
//            rst_b      - synchronous active-low reset
//            bus        - IO bus, slave modport of io_sram_responder_if
//            ram_addr   - SRAM halfword address
//            ram_dq_out - data driven to the SRAM
//            ram_dq_oe  - tri-state enable for ram_dq_out (1 = drive)
//            ram_dq_in  - data returned by the SRAM
//            ram_cs_b   - chip select, active low
//            ram_oe_b   - output enable, active low
//            ram_we_b   - write enable, active low
//            ram_ub_b   - upper byte enable, active low
//            ram_lb_b   - lower byte enable, active low
// Options  : IO_SRAM_FULLREAD_EN - when defined, reads always visit both
//            halves so io_q carries the full word; writes follow io_be.
// Revision : 1.0 - initial release
// ============================================================================
module io_sram_responder #(
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_W      = 20
) (
  input  wire logic              clk,
  input  wire logic              rst_b,
  io_sram_responder_if.slave     bus,
  output logic [ADDR_W-1:0]      ram_addr,
  output logic [15:0]            ram_dq_out,
  output logic                   ram_dq_oe,
  input  wire logic [15:0]       ram_dq_in,
  output logic                   ram_cs_b,
  output logic                   ram_oe_b,
  output logic                   ram_we_b,
  output logic                   ram_ub_b,
  output logic                   ram_lb_b
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETUP  = 3'd1;
  localparam logic [2:0] ST_STROBE = 3'd2;
  localparam logic [2:0] ST_HOLD   = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  localparam logic [3:0] C_WAIT = 4'(WAIT_CYCLES);

  logic [2:0]        r_state;
  logic [3:0]        r_cnt;
  logic [ADDR_W-2:0] r_word;
  logic [1:0]        r_be_hi;
  logic [15:0]       r_di_hi;
  logic              r_wr;
  logic              r_cur_hi;
  logic              r_hi_pend;
  logic [31:0]       r_q;
  logic              r_ready;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_dq_out;
  logic              r_dq_oe;
  logic              r_cs_b;
  logic              r_oe_b;
  logic              r_we_b;
  logic              r_ub_b;
  logic              r_lb_b;

  logic w_req;
  logic w_lo_in;
  logic w_hi_in;
  logic w_unused;

  assign w_req = bus.sel & (bus.io_rd | bus.io_wr);

  // Which halves the incoming request visits; a simultaneous rd+wr is a write.
`ifdef IO_SRAM_FULLREAD_EN
  assign w_lo_in = (|bus.io_be[1:0]) | ~bus.io_wr;
  assign w_hi_in = (|bus.io_be[3:2]) | ~bus.io_wr;
`else
  assign w_lo_in = |bus.io_be[1:0];
  assign w_hi_in = |bus.io_be[3:2];
`endif

  // Byte-address bits below the word boundary carry no information here.
  assign w_unused = &{1'b0, bus.io_a[1:0]};

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 4'd0;
      r_word    <= '0;
      r_be_hi   <= 2'b00;
      r_di_hi   <= 16'h0000;
      r_wr      <= 1'b0;
      r_cur_hi  <= 1'b0;
      r_hi_pend <= 1'b0;
      r_q       <= 32'h0000_0000;
      r_ready   <= 1'b0;
      r_addr    <= '0;
      r_dq_out  <= 16'h0000;
      r_dq_oe   <= 1'b0;
      r_cs_b    <= 1'b1;
      r_oe_b    <= 1'b1;
      r_we_b    <= 1'b1;
      r_ub_b    <= 1'b1;
      r_lb_b    <= 1'b1;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            r_word  <= bus.io_a[ADDR_W:2];
            r_be_hi <= bus.io_be[3:2];
            r_di_hi <= bus.io_di[31:16];
            r_wr    <= bus.io_wr;
            // Reads start from a cleared word so unvisited halves read 0;
            // an empty access also returns 0.
            if (!bus.io_wr || (bus.io_be == 4'b0000)) begin
              r_q <= 32'h0000_0000;
            end
            if (w_lo_in || w_hi_in) begin
              r_state   <= ST_SETUP;
              r_cur_hi  <= ~w_lo_in;
              r_hi_pend <= w_lo_in & w_hi_in;
              r_addr    <= {bus.io_a[ADDR_W:2], ~w_lo_in};
              r_cs_b    <= 1'b0;
              // Reads enable both byte lanes; writes follow the half's enables.
              r_ub_b    <= bus.io_wr & ~(w_lo_in ? bus.io_be[1] : bus.io_be[3]);
              r_lb_b    <= bus.io_wr & ~(w_lo_in ? bus.io_be[0] : bus.io_be[2]);
              r_dq_oe   <= bus.io_wr;
              r_dq_out  <= w_lo_in ? bus.io_di[15:0] : bus.io_di[31:16];
            end else begin
              r_state <= ST_DONE;
              r_ready <= 1'b1;
            end
          end
        end

        ST_SETUP: begin
          r_state <= ST_STROBE;
          r_cnt   <= C_WAIT;
          r_oe_b  <= r_wr;
          r_we_b  <= ~r_wr;
        end

        ST_STROBE: begin
          if (r_cnt == 4'd0) begin
            r_state <= ST_HOLD;
            r_oe_b  <= 1'b1;
            r_we_b  <= 1'b1;
            // Sample the SRAM at the end of the last strobe cycle.
            if (!r_wr) begin
              if (r_cur_hi) begin
                r_q[31:16] <= ram_dq_in;
              end else begin
                r_q[15:0] <= ram_dq_in;
              end
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end

        ST_HOLD: begin
          if (r_hi_pend) begin
            // Chip select and drive stay active into the high-half cycle.
            r_state   <= ST_SETUP;
            r_hi_pend <= 1'b0;
            r_cur_hi  <= 1'b1;
            r_addr    <= {r_word, 1'b1};
            r_ub_b    <= r_wr & ~r_be_hi[1];
            r_lb_b    <= r_wr & ~r_be_hi[0];
            r_dq_out  <= r_di_hi;
          end else begin
            r_state <= ST_DONE;
            r_ready <= 1'b1;
            r_cs_b  <= 1'b1;
            r_ub_b  <= 1'b1;
            r_lb_b  <= 1'b1;
            r_dq_oe <= 1'b0;
          end
        end

        ST_DONE: begin
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.io_q     = r_q;
  assign bus.io_ready = r_ready;
  assign ram_addr     = r_addr;
  assign ram_dq_out   = r_dq_out;
  assign ram_dq_oe    = r_dq_oe;
  assign ram_cs_b     = r_cs_b;
  assign ram_oe_b     = r_oe_b;
  assign ram_we_b     = r_we_b;
  assign ram_ub_b     = r_ub_b;
  assign ram_lb_b     = r_lb_b;

endmodule

`default_nettype wire
